// File: rtl/entropy_pkg.sv
// entropy_pkg: shared defaults and extractor state type for the QRNG entropy front-end.
package entropy_pkg;
    localparam int DEF_WORD_W     = 64;
    localparam int DEF_RCT_CUTOFF = 32;
    localparam int DEF_CNT_W      = 16;
    localparam int RUN_W          = 8;
    typedef enum logic {VN_EMPTY, VN_HALF} vn_state_t;
endpackage

// File: rtl/entropy_rct.sv
// entropy_rct: repetition-count health test on a raw bit stream with a sticky fail flag.
module entropy_rct
    import entropy_pkg::*;
#(
    parameter int RCT_CUTOFF = DEF_RCT_CUTOFF
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_bit,
    input  logic raw_valid,
    output logic fail,
    output logic fail_next
);
    logic [RUN_W-1:0] run_q, run_d;
    logic             last_q, last_d;
    logic             fail_q, fail_d;

    always_comb begin
        run_d  = run_q;
        last_d = last_q;
        fail_d = fail_q;
        if (raw_valid) begin
            run_d  = raw_bit != last_q ? RUN_W'(1) :
                     run_q == RUN_W'(RCT_CUTOFF) ? run_q : run_q + 1'b1;
            last_d = raw_bit;
            fail_d = fail_q | (run_d == RUN_W'(RCT_CUTOFF));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            run_q  <= RUN_W'(1);
            last_q <= 1'b0;
            fail_q <= 1'b0;
        end else begin
            run_q  <= run_d;
            last_q <= last_d;
            fail_q <= fail_d;
        end
    end

    assign fail      = fail_q;
    assign fail_next = fail_d;
endmodule

// File: rtl/entropy_collector.sv
// entropy_collector: RCT-checked von Neumann debiasing of raw QRNG bits, packed into
// words on a valid/ready output with a saturating dropped-word counter.
module entropy_collector
    import entropy_pkg::*;
#(
    parameter int WORD_W     = DEF_WORD_W,
    parameter int RCT_CUTOFF = DEF_RCT_CUTOFF,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              raw_bit,
    input  logic              raw_valid,
    output logic [WORD_W-1:0] entropy_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              rct_fail,
    output logic [CNT_W-1:0]  drop_count
);
    localparam int CW = $clog2(WORD_W);

    vn_state_t         vn_q, vn_d;
    logic              first_q, first_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WORD_W-1:0] shreg_q, shreg_d;
    logic [WORD_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic [CNT_W-1:0]  drop_q, drop_d;
    logic              fail_next, upd, emit, done, buf_free, load;
    logic [WORD_W-1:0] word;

    entropy_rct #(.RCT_CUTOFF(RCT_CUTOFF)) u_rct (
        .clk       (clk),
        .reset     (reset),
        .raw_bit   (raw_bit),
        .raw_valid (raw_valid),
        .fail      (rct_fail),
        .fail_next (fail_next)
    );

    // fail_next blocks the failing edge itself, so a failure beats a same-cycle word completion.
    always_comb begin
        upd      = enable && raw_valid && !fail_next;
        emit     = upd && vn_q == VN_HALF && raw_bit != first_q;
        word     = {shreg_q[WORD_W-2:0], first_q};
        done     = emit && cnt_q == CW'(WORD_W - 1);
        buf_free = !valid_q || out_ready;
        load     = done && buf_free;
        vn_d     = vn_q;
        if (!enable)
            vn_d = VN_EMPTY;
        else if (upd)
            vn_d = vn_q == VN_EMPTY ? VN_HALF : VN_EMPTY;
        first_d = upd && vn_q == VN_EMPTY ? raw_bit : first_q;
        cnt_d   = !enable || done ? '0 : emit ? cnt_q + 1'b1 : cnt_q;
        shreg_d = emit ? word : shreg_q;
        data_d  = load ? word : data_q;
        valid_d = fail_next ? 1'b0 : load ? 1'b1 : valid_q && !out_ready;
        drop_d  = done && !buf_free && drop_q != '1 ? drop_q + 1'b1 : drop_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vn_q    <= VN_EMPTY;
            first_q <= 1'b0;
            cnt_q   <= '0;
            shreg_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            drop_q  <= '0;
        end else begin
            vn_q    <= vn_d;
            first_q <= first_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            drop_q  <= drop_d;
        end
    end

    assign entropy_data = data_q;
    assign out_valid    = valid_q;
    assign drop_count   = drop_q;
endmodule

// File: tb/tb_entropy_collector.sv
// tb_entropy_collector: directed stimulus with a scoreboard queue of expected words,
// popped by a monitor on every output transfer.
module tb_entropy_collector;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b1;
    logic        raw_bit = 1'b0;
    logic        raw_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [63:0] entropy_data;
    logic        out_valid;
    logic        rct_fail;
    logic [15:0] drop_count;

    int checks = 0;
    int errors = 0;
    int xfers  = 0;
    logic [63:0] sb[$];

    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] W1 = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] W2 = 64'hFEDC_BA98_7654_3210;
    localparam logic [63:0] W3 = 64'h5555_AAAA_3333_CCCC;
    localparam logic [63:0] W4 = 64'hA5A5_0F0F_1234_8765;
    localparam logic [63:0] W5 = 64'hDEAD_BEEF_CAFE_F00D;

    entropy_collector dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .raw_bit      (raw_bit),
        .raw_valid    (raw_valid),
        .entropy_data (entropy_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .rct_fail     (rct_fail),
        .drop_count   (drop_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            xfers++;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_word: got %h expected no transfer", entropy_data);
            end else begin
                logic [63:0] exp;
                exp = sb.pop_front();
                if (entropy_data !== exp) begin
                    errors++;
                    $display("FAIL word_data: got %h expected %h", entropy_data, exp);
                end
            end
        end
    end

    task automatic send_bit(input logic b);
        raw_bit   = b;
        raw_valid = 1'b1;
        @(posedge clk);
        #1;
        raw_valid = 1'b0;
    endtask

    task automatic send_pair(input logic a, input logic b);
        send_bit(a);
        send_bit(b);
    endtask

    task automatic send_word(input logic [63:0] w);
        for (int i = 63; i >= 0; i--) send_pair(w[i], !w[i]);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        int x0;
        idle(2);
        check("reset_data", entropy_data, 64'h0);
        check("reset_valid", 64'(out_valid), 64'h0);
        check("reset_rct", 64'(rct_fail), 64'h0);
        check("reset_drop", 64'(drop_count), 64'h0);
        reset = 1'b0;
        // Test 1: held word plus 30 partial bits, then async reset
        send_word(ONES);
        check("t1_held_valid", 64'(out_valid), 64'h1);
        for (int i = 0; i < 30; i++) send_pair(1'b1, 1'b0);
        reset = 1'b1;
        #2;
        check("t1_async_valid", 64'(out_valid), 64'h0);
        check("t1_async_data", entropy_data, 64'h0);
        check("t1_async_drop", 64'(drop_count), 64'h0);
        idle(1);
        reset = 1'b0;
        out_ready = 1'b1;
        x0 = xfers;
        for (int i = 0; i < 63; i++) send_pair(1'b0, 1'b1);
        check("t1_no_early_word", 64'(xfers - x0), 64'h0);
        sb.push_back(64'h0);
        send_pair(1'b0, 1'b1);
        check("t1_valid_after_64", 64'(out_valid), 64'h1);
        idle(1);
        check("t1_valid_pulse", 64'(out_valid), 64'h0);
        // Test 2: alternating pairs
        sb.push_back(ONES);
        for (int i = 0; i < 64; i++) send_pair(1'b1, 1'b0);
        check("t2_valid", 64'(out_valid), 64'h1);
        check("t2_data", entropy_data, ONES);
        idle(1);
        check("t2_valid_pulse", 64'(out_valid), 64'h0);
        sb.push_back(64'h0);
        for (int i = 0; i < 64; i++) send_pair(1'b0, 1'b1);
        check("t2_data_zero", entropy_data, 64'h0);
        idle(1);
        // Test 3: equal pairs discarded
        x0 = xfers;
        sb.push_back(ONES);
        for (int i = 0; i < 63; i++) begin
            send_pair(1'b1, 1'b0);
            send_pair(1'b1, 1'b1);
        end
        check("t3_no_early_word", 64'(xfers - x0), 64'h0);
        send_pair(1'b1, 1'b0);
        send_pair(1'b1, 1'b1);
        idle(1);
        check("t3_one_word", 64'(xfers - x0), 64'h1);
        // Test 4: backpressure
        out_ready = 1'b0;
        send_word(W1);
        send_word(W2);
        send_word(W3);
        check("t4_valid_held", 64'(out_valid), 64'h1);
        check("t4_drop", 64'(drop_count), 64'h2);
        check("t4_data_first", entropy_data, W1);
        x0 = xfers;
        sb.push_back(W1);
        out_ready = 1'b1;
        idle(1);
        check("t4_valid_clear", 64'(out_valid), 64'h0);
        check("t4_one_xfer", 64'(xfers - x0), 64'h1);
        // Test 6: enable flush with a held word outstanding
        out_ready = 1'b0;
        send_word(W4);
        for (int i = 0; i < 40; i++) send_pair(1'b1, 1'b0);
        enable = 1'b0;
        for (int i = 0; i < 10; i++) send_pair(1'b1, 1'b0);
        check("t6_valid_kept", 64'(out_valid), 64'h1);
        check("t6_drop_kept", 64'(drop_count), 64'h2);
        check("t6_data_kept", entropy_data, W4);
        sb.push_back(W4);
        out_ready = 1'b1;
        idle(1);
        check("t6_handshake_disabled", 64'(out_valid), 64'h0);
        enable = 1'b1;
        x0 = xfers;
        sb.push_back(64'h0);
        for (int i = 0; i < 64; i++) send_pair(1'b0, 1'b1);
        idle(1);
        check("t6_one_word", 64'(xfers - x0), 64'h1);
        check("t6_data_fresh", entropy_data, 64'h0);
        // Test 5: RCT failure with a pending word
        out_ready = 1'b0;
        send_word(W5);
        check("t5_pending", 64'(out_valid), 64'h1);
        for (int i = 0; i < 31; i++) send_bit(1'b1);
        check("t5_rct_before", 64'(rct_fail), 64'h0);
        send_bit(1'b1);
        check("t5_rct_set", 64'(rct_fail), 64'h1);
        idle(1);
        check("t5_valid_cleared", 64'(out_valid), 64'h0);
        out_ready = 1'b1;
        x0 = xfers;
        for (int i = 0; i < 64; i++) send_pair(1'b1, 1'b0);
        idle(2);
        check("t5_no_load", 64'(xfers - x0), 64'h0);
        check("t5_valid_stays_low", 64'(out_valid), 64'h0);
        check("t5_data_held", entropy_data, W5);
        check("t5_rct_sticky", 64'(rct_fail), 64'h1);
        check("sb_drained", 64'(sb.size()), 64'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
